// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts out one command byte with odd parity, and checks the device ACK.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] DATA_IN,
  input  logic       PS2CLK_IN,
  input  logic       PS2DATA_IN,
  output logic       PS2CLK_OE,
  output logic       PS2DATA_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0]      edge_cnt_q, edge_cnt_d;
  logic [8:0]      shreg_q, shreg_d;
  logic            err_flag_q, err_flag_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            ps2clk_meta_q, ps2clk_sync_q, ps2clk_prev_q;
  logic            ps2data_meta_q, ps2data_sync_q;
  logic            ps2clk_fall;

  assign ps2clk_fall = ps2clk_prev_q & ~ps2clk_sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ps2clk_meta_q  <= 1'b0;
      ps2clk_sync_q  <= 1'b0;
      ps2clk_prev_q  <= 1'b0;
      ps2data_meta_q <= 1'b0;
      ps2data_sync_q <= 1'b0;
    end else begin
      ps2clk_meta_q  <= PS2CLK_IN;
      ps2clk_sync_q  <= ps2clk_meta_q;
      ps2clk_prev_q  <= ps2clk_sync_q;
      ps2data_meta_q <= PS2DATA_IN;
      ps2data_sync_q <= ps2data_meta_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      edge_cnt_q <= '0;
      shreg_q    <= '0;
      err_flag_q <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      shreg_q    <= shreg_d;
      err_flag_q <= err_flag_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Line enables are registered: each value below is what the bus sees next cycle.
  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    edge_cnt_d = edge_cnt_q;
    shreg_d    = shreg_q;
    err_flag_d = err_flag_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (START) begin
          state_d    = INHIBIT;
          shreg_d    = {~^DATA_IN, DATA_IN};
          inh_cnt_d  = '0;
          edge_cnt_d = '0;
          err_flag_d = 1'b0;
          clk_oe_d   = 1'b1;
          data_oe_d  = (INH_LAST == '0);
          busy_d     = 1'b1;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          state_d   = REQ;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          to_cnt_d  = '0;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
          data_oe_d = (inh_cnt_d == INH_LAST);
        end
      end
      REQ: begin
        state_d    = SHIFT;
        edge_cnt_d = '0;
      end
      SHIFT: begin
        if (ps2clk_fall) begin
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (edge_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~shreg_q[0];
            shreg_d   = {1'b0, shreg_q[8:1]};
          end
        end
      end
      ACK: begin
        if (ps2clk_fall) begin
          err_flag_d = ps2data_sync_q;
          state_d    = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (ps2clk_sync_q && ps2data_sync_q) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = ~err_flag_q;
          err_d      = err_flag_q;
          err_flag_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout overrides any edge handling in the same cycle.
    if (state_q == REQ || state_q == SHIFT || state_q == ACK) begin
      to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
      if (to_cnt_q >= TO_LAST) begin
        state_d    = IDLE;
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b1;
        err_flag_d = 1'b0;
      end
    end
  end

  assign PS2CLK_OE  = clk_oe_q;
  assign PS2DATA_OE = data_oe_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector PS/2 device model plus a frame-level
// reference model of the expected host-to-device bit stream.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TMO  = 2500;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2clk_line, ps2data_line;
  logic       ps2clk_oe, ps2data_oe, busy, done, err;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int busy_bad = 0;
  int clk_oe_bad = 0;
  logic busy_prev = 1'b0;

  assign ps2clk_line  = dev_clk & ~ps2clk_oe;
  assign ps2data_line = dev_data & ~ps2data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(clk), .RST(rst), .START(start), .DATA_IN(data_in),
    .PS2CLK_IN(ps2clk_line), .PS2DATA_IN(ps2data_line),
    .PS2CLK_OE(ps2clk_oe), .PS2DATA_OE(ps2data_oe),
    .BUSY(busy), .DONE(done), .ERR(err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Event counters: pulse cycles, DONE/ERR overlap, BUSY relation, clock-drive sanity.
  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
      if ((done || err) && (busy || !busy_prev)) busy_bad++;
      if (ps2clk_oe && !busy) clk_oe_bad++;
      busy_prev = busy;
    end
  end

  // Reference frame: index 0 start bit, 1..8 data LSB first, 9 odd parity, 10 stop.
  function automatic logic [10:0] expected_frame(input logic [7:0] b);
    logic [10:0] r;
    int ones, v;
    ones = 0;
    v = int'(b);
    r[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r[i+1] = logic'(v % 2);
      ones += v % 2;
      v = v / 2;
    end
    r[9]  = (ones % 2 == 0);
    r[10] = 1'b1;
    return r;
  endfunction

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    data_in = b;
    @(negedge clk);
    start = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic measure_inhibit(input string tag);
    int n;
    logic last, prev;
    n = 0; last = 1'b0; prev = 1'b0;
    while (ps2clk_oe === 1'b1 && n < INH + 20) begin
      prev = last;
      last = ps2data_oe;
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n != INH) begin n_fail++; $display("FAIL %s inhibit_len: got %0d expected %0d", tag, n, INH); end
    n_checks++;
    if (last !== 1'b1 || prev !== 1'b0) begin
      n_fail++; $display("FAIL %s inhibit_data_oe: got last=%b prev=%b expected last=1 prev=0", tag, last, prev);
    end
    n_checks++;
    if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL %s req_lines: got clk_oe=%b data_oe=%b busy=%b expected 0 1 1", tag, ps2clk_oe, ps2data_oe, busy);
    end
  endtask

  task automatic dev_frame(input logic nack, input int abort_after, output logic [10:0] got);
    got = '0;
    repeat (10) @(negedge clk);
    got[0] = ps2data_line;
    for (int e = 1; e <= 10; e++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      got[e] = ps2data_line;
      dev_clk = 1'b1;
      if (e == abort_after) return;
      repeat (HALF) @(negedge clk);
    end
    dev_data = nack;
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_outcome(input int d0, input int e0);
    int k;
    k = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] b, input logic nack, output logic [10:0] got);
    int d0, e0;
    logic [10:0] exp_f;
    exp_f = expected_frame(b);
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(b);
    n_checks++;
    if (busy !== 1'b1 || ps2clk_oe !== 1'b1) begin
      n_fail++; $display("FAIL %s after_start: got busy=%b clk_oe=%b expected 1 1", tag, busy, ps2clk_oe);
    end
    measure_inhibit(tag);
    dev_frame(nack, 0, got);
    wait_outcome(d0, e0);
    n_checks++;
    if (got !== exp_f) begin n_fail++; $display("FAIL %s frame: got %b expected %b", tag, got, exp_f); end
    n_checks++;
    if (done_cnt - d0 != (nack ? 0 : 1) || err_cnt - e0 != (nack ? 1 : 0)) begin
      n_fail++; $display("FAIL %s outcome: got done=%0d err=%0d expected done=%0d err=%0d",
                         tag, done_cnt - d0, err_cnt - e0, nack ? 0 : 1, nack ? 1 : 0);
    end
    n_checks++;
    if (busy !== 1'b0 || ps2data_oe !== 1'b0 || ps2clk_oe !== 1'b0) begin
      n_fail++; $display("FAIL %s end_idle: got busy=%b clk_oe=%b data_oe=%b expected 0 0 0", tag, busy, ps2clk_oe, ps2data_oe);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ps2clk_oe, ps2data_oe, busy, done, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {ps2clk_oe, ps2data_oe, busy, done, err});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({ps2clk_oe, ps2data_oe, busy, done, err} !== 5'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got %b expected 00000", {ps2clk_oe, ps2data_oe, busy, done, err});
    end
  endtask

  task automatic test_idle_traffic;
    int d0, e0;
    logic bad;
    d0 = done_cnt; e0 = err_cnt; bad = 1'b0;
    for (int e = 0; e < 11; e++) begin
      dev_data = 1'($urandom);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (ps2clk_oe || ps2data_oe || busy) bad = 1'b1;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (ps2clk_oe || ps2data_oe || busy) bad = 1'b1;
    end
    dev_data = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (bad !== 1'b0 || done_cnt != d0 || err_cnt != e0) begin
      n_fail++; $display("FAIL idle_traffic: got bad=%b pulses=%0d expected bad=0 pulses=0", bad, done_cnt - d0 + err_cnt - e0);
    end
  endtask

  task automatic test_ed;
    logic [10:0] got;
    run_xfer("xfer_ed", 8'hED, 1'b0, got);
    n_checks++;
    if (got[10:1] !== 10'h3ED) begin n_fail++; $display("FAIL ed_bits: got %b expected %b", got[10:1], 10'h3ED); end
  endtask

  task automatic test_parity;
    logic [10:0] got;
    run_xfer("xfer_07", 8'h07, 1'b0, got);
    n_checks++;
    if (got[9] !== 1'b0) begin n_fail++; $display("FAIL parity_07: got %b expected 0", got[9]); end
    run_xfer("xfer_00", 8'h00, 1'b0, got);
    n_checks++;
    if (got[9] !== 1'b1) begin n_fail++; $display("FAIL parity_00: got %b expected 1", got[9]); end
  endtask

  task automatic test_nack;
    logic [10:0] got;
    run_xfer("xfer_nack", 8'h5A, 1'b1, got);
  endtask

  task automatic test_timeout;
    int k;
    pulse_start(8'h3C);
    measure_inhibit("timeout");
    k = 0;
    while (err !== 1'b1 && k < TMO + 50) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k != TMO) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", k, TMO); end
    n_checks++;
    if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_lines: got clk_oe=%b data_oe=%b busy=%b done=%b expected 0 0 0 0", ps2clk_oe, ps2data_oe, busy, done);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse: got %b expected 0", err); end
  endtask

  task automatic test_start_ignored;
    int d0, e0;
    logic [10:0] got, exp_f;
    exp_f = expected_frame(8'h96);
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(8'h96);
    measure_inhibit("ignored");
    fork
      dev_frame(1'b0, 0, got);
      begin
        repeat (150) @(negedge clk);
        start = 1'b1;
        data_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_outcome(d0, e0);
    repeat (INH + 20) @(negedge clk);
    n_checks++;
    if (got !== exp_f) begin n_fail++; $display("FAIL ignored_frame: got %b expected %b", got, exp_f); end
    n_checks++;
    if (done_cnt - d0 != 1 || err_cnt != e0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ignored_outcome: got done=%0d err=%0d busy=%b expected 1 0 0", done_cnt - d0, err_cnt - e0, busy);
    end
  endtask

  task automatic test_reset_mid;
    int d0, e0;
    logic [10:0] got;
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(8'hA5);
    measure_inhibit("rst_mid");
    dev_frame(1'b0, 5, got);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got clk_oe=%b data_oe=%b busy=%b expected 0 0 0", ps2clk_oe, ps2data_oe, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      n_fail++; $display("FAIL rst_no_pulse: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    run_xfer("after_rst", 8'h3E, 1'b0, got);
  endtask

  task automatic test_random;
    logic [10:0] got;
    logic [7:0] b;
    logic nack;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      nack = ($urandom_range(0, 3) == 0);
      run_xfer("random", b, nack, got);
    end
  endtask

  task automatic test_monitors;
    n_checks++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL done_err_overlap: got %0d expected 0", both_cnt); end
    n_checks++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL busy_with_pulse: got %0d expected 0", busy_bad); end
    n_checks++;
    if (clk_oe_bad != 0) begin n_fail++; $display("FAIL clk_oe_outside_xfer: got %0d expected 0", clk_oe_bad); end
  endtask

  initial begin
    test_reset();
    test_idle_traffic();
    test_ed();
    test_parity();
    test_nack();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_monitors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
